// File: rtl/timer_apb_slave.sv
// 8-bit prescaled up/down timer behind an APB register responder.
// Holds TDR/TCR/TSR/TCNT; overflow/underflow flags are set only by real count wraps.
module timer_apb_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              ovf_int,
  output logic              udf_int
);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tdr_q, tdr_d;
  logic [DATA_W-1:0] tcr_q, tcr_d;
  logic [1:0]        tsr_q, tsr_d;
  logic [DATA_W-1:0] tcnt_q, tcnt_d;
  logic [3:0]        presc_q, presc_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;

  logic              addr_err, acc_err, wr_ok, tick;
  logic [3:0]        tick_mask;
  logic [1:0]        tsr_set, tsr_clr;
  logic [DATA_W-1:0] rdata_mux;

  // Bus FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (psel && !penable) state_d = SETUP;
      SETUP: begin
        if (!psel)        state_d = IDLE;
        else if (penable) state_d = (WAIT_STATES == 1) ? WAIT : ACCESS;
      end
      WAIT:    state_d = psel ? ACCESS : IDLE;
      ACCESS:  state_d = (psel && !penable) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_err = (paddr > ADDR_W'(3));
    acc_err  = addr_err || (pwrite && (paddr == ADDR_W'(3)));
    rdata_mux = '0;
    if (!addr_err) begin
      case (paddr[1:0])
        2'd0:    rdata_mux = tdr_q;
        2'd1:    rdata_mux = tcr_q;
        2'd2:    rdata_mux = {{(DATA_W-2){1'b0}}, tsr_q};
        default: rdata_mux = tcnt_q;
      endcase
    end
    // Response is captured on entry to ACCESS so it is registered while pready is high.
    prdata_d  = (state_d == ACCESS && !pwrite && !acc_err) ? rdata_mux : '0;
    pslverr_d = (state_d == ACCESS) && acc_err;
    wr_ok     = (state_q == ACCESS) && pwrite && !pslverr_q;
  end

  // Register file, prescaler and counter
  always_comb begin
    tdr_d   = tdr_q;
    tcr_d   = tcr_q;
    tsr_clr = '0;
    if (wr_ok) begin
      case (paddr[1:0])
        2'd0:    tdr_d   = pwdata;
        2'd1:    tcr_d   = pwdata & DATA_W'(8'hB3);
        2'd2:    tsr_clr = pwdata[1:0];
        default: ;
      endcase
    end

    presc_d = presc_q + 4'd1;
    case (tcr_q[1:0])
      2'd0:    tick_mask = 4'b0001;
      2'd1:    tick_mask = 4'b0011;
      2'd2:    tick_mask = 4'b0111;
      default: tick_mask = 4'b1111;
    endcase
    tick = ((presc_q & tick_mask) == tick_mask);

    // Load path never touches flags, so a TDR wrap seen through load is not an overflow.
    tcnt_d  = tcnt_q;
    tsr_set = '0;
    if (tcr_q[7]) begin
      tcnt_d = tdr_q;
    end else if (tcr_q[4] && tick) begin
      if (tcr_q[5]) begin
        tcnt_d     = tcnt_q - DATA_W'(1);
        tsr_set[1] = (tcnt_q == '0);
      end else begin
        tcnt_d     = tcnt_q + DATA_W'(1);
        tsr_set[0] = (tcnt_q == '1);
      end
    end
    tsr_d = (tsr_q & ~tsr_clr) | tsr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tdr_q     <= '0;
      tcr_q     <= '0;
      tsr_q     <= '0;
      tcnt_q    <= '0;
      presc_q   <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tdr_q     <= tdr_d;
      tcr_q     <= tcr_d;
      tsr_q     <= tsr_d;
      tcnt_q    <= tcnt_d;
      presc_q   <= presc_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;
  assign pready  = (state_q == ACCESS);
  assign ovf_int = tsr_q[0];
  assign udf_int = tsr_q[1];

endmodule

// File: tb/tb_timer_apb_slave.sv
// Self-checking bench for timer_apb_slave: APB transfers scored against a cycle reference model.
module tb_timer_apb_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata;
  logic       pready, pslverr, ovf_int, udf_int;

  timer_apb_slave #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .ovf_int(ovf_int), .udf_int(udf_int)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model of the timer registers
  logic [7:0] m_tdr, m_tcr, m_tcnt;
  logic [1:0] m_tsr, m_set, m_clr;
  logic [3:0] m_presc;
  logic       m_tick;
  logic       wr_pend = 1'b0;
  logic [7:0] w_addr, w_data;

  always @(posedge clk) begin
    if (rst) begin
      m_tdr <= 8'h00; m_tcr <= 8'h00; m_tsr <= 2'b00; m_tcnt <= 8'h00; m_presc <= 4'h0;
    end else begin
      m_tick = ((int'(m_presc) + 1) % (2 << m_tcr[1:0])) == 0;
      m_set  = 2'b00;
      m_clr  = 2'b00;
      m_presc <= m_presc + 4'd1;
      if (m_tcr[7]) m_tcnt <= m_tdr;
      else if (m_tcr[4] && m_tick) begin
        if (m_tcr[5]) begin
          if (m_tcnt == 8'h00) begin m_set[1] = 1'b1; m_tcnt <= 8'hFF; end
          else m_tcnt <= m_tcnt - 8'd1;
        end else begin
          if (m_tcnt == 8'hFF) begin m_set[0] = 1'b1; m_tcnt <= 8'h00; end
          else m_tcnt <= m_tcnt + 8'd1;
        end
      end
      if (wr_pend) begin
        if (w_addr == 8'h00) m_tdr <= w_data;
        if (w_addr == 8'h01) m_tcr <= {w_data[7], 1'b0, w_data[5:4], 2'b00, w_data[1:0]};
        if (w_addr == 8'h02) m_clr = w_data[1:0];
      end
      m_tsr <= (m_tsr & ~m_clr) | m_set;
    end
  end

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return m_tdr;
      8'h01:   return m_tcr;
      8'h02:   return {6'b0, m_tsr};
      default: return m_tcnt;
    endcase
  endfunction

  typedef struct {
    logic       wr;
    logic       err;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];

  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                     output logic [7:0] rd);
    exp_t e;
    int unsigned cyc;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    e.wr    = wr;
    e.err   = (addr > 8'h03) || (wr && addr == 8'h03);
    e.rdata = (wr || e.err) ? 8'h00 : model_read(addr);
    sb.push_back(e);
    cyc = 1;
    while (!pready && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pready_timeout", {31'b0, pready}, 32'd1);
    check("access_latency", cyc, 32'd2);
    e = sb.pop_front();
    if (!e.wr || e.err) check("prdata", {24'b0, prdata}, {24'b0, e.rdata});
    check("pslverr", {31'b0, pslverr}, {31'b0, e.err});
    rd = prdata;
    if (wr && !e.err) begin
      wr_pend = 1'b1; w_addr = addr; w_data = wdata;
    end
    @(posedge clk); #1;
    wr_pend = 1'b0;
    check("pready_one_cycle", {31'b0, pready}, 32'd0);
    check("prdata_idle", {24'b0, prdata}, 32'd0);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    apb(1'b1, a, d, dummy);
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
    apb(1'b0, a, 8'h00, d);
  endtask

  task automatic wait_presc(input logic [3:0] v);
    int unsigned n = 0;
    while (m_presc != v && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  logic [7:0] rv, saved;
  int unsigned cyc;

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", {31'b0, pready}, 32'd0);
    check("rst_prdata", {24'b0, prdata}, 32'd0);
    check("rst_pslverr", {31'b0, pslverr}, 32'd0);
    check("rst_ovf_int", {31'b0, ovf_int}, 32'd0);
    check("rst_udf_int", {31'b0, udf_int}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_reg(8'(i), rv);
      check("rst_reg_zero", {24'b0, rv}, 32'd0);
    end

    // Load-path wraps must not raise flags
    wr_reg(8'h00, 8'hFF); wr_reg(8'h01, 8'h80);
    wr_reg(8'h00, 8'h00); wr_reg(8'h01, 8'h80);
    rd_reg(8'h02, rv); check("fake_ovf_en0", {24'b0, rv}, 32'd0);
    wr_reg(8'h00, 8'hFF); wr_reg(8'h01, 8'h90);
    wr_reg(8'h00, 8'h00);
    rd_reg(8'h02, rv); check("fake_ovf_en1", {24'b0, rv}, 32'd0);
    wr_reg(8'h00, 8'hFF);
    rd_reg(8'h02, rv); check("fake_udf_en1", {24'b0, rv}, 32'd0);
    rd_reg(8'h01, rv); check("tcr_readback", {24'b0, rv}, 32'h90);

    // Up count through 0xFF -> 0x00
    wr_reg(8'h00, 8'hFE); wr_reg(8'h01, 8'h80); wr_reg(8'h01, 8'h10);
    rd_reg(8'h03, rv);
    rd_reg(8'h03, rv);
    cyc = 0;
    while (!ovf_int && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("ovf_int", {31'b0, ovf_int}, 32'd1);
    wr_reg(8'h01, 8'h00);
    rd_reg(8'h02, rv); check("tsr_ovf", {24'b0, rv}, 32'h01);
    wr_reg(8'h02, 8'h01);
    rd_reg(8'h02, rv); check("tsr_ovf_clr", {24'b0, rv}, 32'h00);

    // Down count through 0x00 -> 0xFF
    wr_reg(8'h00, 8'h01); wr_reg(8'h01, 8'h80); wr_reg(8'h01, 8'h31);
    rd_reg(8'h03, rv);
    cyc = 0;
    while (!udf_int && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("udf_int", {31'b0, udf_int}, 32'd1);
    wr_reg(8'h01, 8'h20);
    rd_reg(8'h02, rv); check("tsr_udf", {24'b0, rv}, 32'h02);
    wr_reg(8'h02, 8'h02);
    rd_reg(8'h02, rv); check("tsr_udf_clr", {24'b0, rv}, 32'h00);

    // W1C commit lands on the same edge as an underflow
    wr_reg(8'h00, 8'h00); wr_reg(8'h01, 8'hA3);
    wait_presc(4'd0);
    wr_reg(8'h01, 8'h33);
    wait_presc(4'd12);
    wr_reg(8'h02, 8'h02);
    rd_reg(8'h02, rv); check("set_beats_clear", {24'b0, rv}, 32'h02);
    check("udf_int_held", {31'b0, udf_int}, 32'd1);

    // Error responses
    wr_reg(8'h01, 8'h00);
    rd_reg(8'h03, saved);
    wr_reg(8'h03, 8'h55);
    rd_reg(8'h07, rv); check("bad_addr_rdata", {24'b0, rv}, 32'd0);
    rd_reg(8'h03, rv); check("tcnt_unchanged", {24'b0, rv}, {24'b0, saved});

    // Reset during the WAIT cycle of a TDR write
    wr_reg(8'h00, 8'h3C);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hAA;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("wait_pready", {31'b0, pready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_pready", {31'b0, pready}, 32'd0);
    check("abort_prdata", {24'b0, prdata}, 32'd0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rd_reg(8'h00, rv); check("abort_tdr", {24'b0, rv}, 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
